truth_table_sweeper: RTL and testbench

- Sequential stimulus/capture stage for the lab's 4-input combinational logic blocks.
- Drives the shared inputs x1..x4 through all 16 combinations and samples the outputs of two implementations: channel A (NAND-form SOP) and channel B (NOR-form POS).
- Builds a 16-bit captured truth table per channel and compares each against an expected mask.
- Reports pass/fail with per-minterm mismatch masks, so a block can be checked in simulation or on the board.

---
 rtl/truth_table_sweeper_pkg.sv | 18 +
 rtl/truth_table_sweeper_if.sv | 31 +++
 rtl/truth_table_sweeper.sv | 99 +++++++++
 tb/tb_truth_table_sweeper.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared state encodings, default masks and settle bounds
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // f = x1'x2x4' + x1x2 + x3'x4 and its product-of-sums counterpart
  localparam logic [15:0] DEF_EXP_A = 16'hF272;
  localparam logic [15:0] DEF_EXP_B = 16'hF266;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - stimulus/capture bus between sweeper and the blocks under test
interface truth_table_sweeper_if;

  logic        start;
  logic        in_a;
  logic        in_b;
  logic        x1;
  logic        x2;
  logic        x3;
  logic        x4;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] table_a;
  logic [15:0] table_b;
  logic [15:0] mism_a;
  logic [15:0] mism_b;

  modport master (
    output start, in_a, in_b,
    input  x1, x2, x3, x4, busy, done, pass,
    input  table_a, table_b, mism_a, mism_b
  );

  modport slave (
    input  start, in_a, in_b,
    output x1, x2, x3, x4, busy, done, pass,
    output table_a, table_b, mism_a, mism_b
  );

endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps x1..x4 through all 16 vectors and captures two truth tables
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int          SETTLE = 2,
  parameter logic [15:0] EXP_A  = DEF_EXP_A,
  parameter logic [15:0] EXP_B  = DEF_EXP_B
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_x;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tab_a;
  logic [15:0] r_tab_b;

  logic [15:0] w_mism_a;
  logic [15:0] w_mism_b;
  logic        w_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tab_a <= '0;
      r_tab_b <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // a fresh sweep discards any held results
          if (bus.start) begin
            r_state <= ST_DRIVE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_tab_a <= '0;
            r_tab_b <= '0;
          end
        end
        ST_DRIVE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_tab_a[r_idx] <= bus.in_a;
          r_tab_b[r_idx] <= bus.in_b;
          r_cnt          <= '0;
          if (r_idx == 4'd15) begin
            r_state <= ST_DONE;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_DRIVE;
            r_idx   <= r_idx + 4'd1;
            r_x     <= r_idx + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // mismatch masks only mean something once the tables are complete
  assign w_mism_a = r_done ? (r_tab_a ^ EXP_A) : '0;
  assign w_mism_b = r_done ? (r_tab_b ^ EXP_B) : '0;
  assign w_pass   = r_done && (w_mism_a == '0) && (w_mism_b == '0);

  assign bus.x1      = r_x[3];
  assign bus.x2      = r_x[2];
  assign bus.x3      = r_x[1];
  assign bus.x4      = r_x[0];
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = w_pass;
  assign bus.table_a = r_tab_a;
  assign bus.table_b = r_tab_b;
  assign bus.mism_a  = w_mism_a;
  assign bus.mism_b  = w_mism_b;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  localparam int SET0 = 2;
  localparam int SET1 = 1;
  localparam logic [15:0] EA = 16'hF272;
  localparam logic [15:0] EB = 16'hF266;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] flip_a = '0;
  logic [15:0] flip_b = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if bus0();
  truth_table_sweeper_if bus1();

  truth_table_sweeper #(.SETTLE(SET0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  truth_table_sweeper #(.SETTLE(SET1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic gold_a(logic [3:0] v);
    logic x1, x2, x3, x4;
    {x1, x2, x3, x4} = v;
    return (~x1 & x2 & ~x4) | (x1 & x2) | (~x3 & x4);
  endfunction

  function automatic logic gold_b(logic [3:0] v);
    logic x1, x2, x3, x4;
    {x1, x2, x3, x4} = v;
    return (~x1 | x2 | ~x3) & (x1 | ~x3 | ~x4) & (x1 | x3 | x4) & (x2 | x3 | x4);
  endfunction

  logic [3:0]  d_x[2];
  logic        d_busy[2], d_done[2], d_pass[2];
  logic [15:0] d_ta[2], d_tb[2], d_ma[2], d_mb[2];

  assign d_x[0] = {bus0.x1, bus0.x2, bus0.x3, bus0.x4};
  assign d_x[1] = {bus1.x1, bus1.x2, bus1.x3, bus1.x4};
  assign d_busy[0] = bus0.busy;   assign d_busy[1] = bus1.busy;
  assign d_done[0] = bus0.done;   assign d_done[1] = bus1.done;
  assign d_pass[0] = bus0.pass;   assign d_pass[1] = bus1.pass;
  assign d_ta[0] = bus0.table_a;  assign d_ta[1] = bus1.table_a;
  assign d_tb[0] = bus0.table_b;  assign d_tb[1] = bus1.table_b;
  assign d_ma[0] = bus0.mism_a;   assign d_ma[1] = bus1.mism_a;
  assign d_mb[0] = bus0.mism_b;   assign d_mb[1] = bus1.mism_b;

  // channels under test: golden function with optional per-minterm faults
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.in_a = gold_a(d_x[0]) ^ flip_a[d_x[0]];
  assign bus0.in_b = gold_b(d_x[0]) ^ flip_b[d_x[0]];
  assign bus1.in_a = gold_a(d_x[1]) ^ flip_a[d_x[1]];
  assign bus1.in_b = gold_b(d_x[1]) ^ flip_b[d_x[1]];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int settle_of(int i);
    return (i == 0) ? SET0 : SET1;
  endfunction

  // model: edges elapsed since the accepted start, and the fault set latched then
  int          mk[2]   = '{0, 0};
  bit          mact[2] = '{1'b0, 1'b0};
  logic [15:0] mfa[2]  = '{16'h0, 16'h0};
  logic [15:0] mfb[2]  = '{16'h0, 16'h0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int len;
      len = 16 * (settle_of(i) + 1);
      if (rst) begin
        mact[i] = 1'b0;
        mk[i]   = 0;
      end else if (start && !(mact[i] && mk[i] < len)) begin
        mact[i] = 1'b1;
        mk[i]   = 0;
        mfa[i]  = flip_a;
        mfb[i]  = flip_b;
      end else if (mact[i] && mk[i] < len) begin
        mk[i] = mk[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int len, per, n;
      bit be, de;
      logic [15:0] msk;
      per = settle_of(i) + 1;
      len = 16 * per;
      be  = mact[i] && (mk[i] < len);
      de  = mact[i] && (mk[i] >= len);
      n   = be ? (mk[i] / per) : (de ? 16 : 0);
      msk = (n == 16) ? 16'hFFFF : ((16'(1) << n) - 16'(1));
      chk($sformatf("d%0d.busy", i), 32'(d_busy[i]), 32'(be));
      chk($sformatf("d%0d.done", i), 32'(d_done[i]), 32'(de));
      chk($sformatf("d%0d.x", i), 32'(d_x[i]), be ? 32'(mk[i] / per) : 32'd0);
      chk($sformatf("d%0d.table_a", i), 32'(d_ta[i]), 32'((EA ^ mfa[i]) & msk));
      chk($sformatf("d%0d.table_b", i), 32'(d_tb[i]), 32'((EB ^ mfb[i]) & msk));
      chk($sformatf("d%0d.mism_a", i), 32'(d_ma[i]), de ? 32'(mfa[i]) : 32'd0);
      chk($sformatf("d%0d.mism_b", i), 32'(d_mb[i]), de ? 32'(mfb[i]) : 32'd0);
      chk($sformatf("d%0d.pass", i), 32'(d_pass[i]),
          32'(de && mfa[i] == 16'h0 && mfb[i] == 16'h0));
    end
  end

  int c0, c1, lr1;

  task automatic run_sweep(int p1, int p2);
    bit prev1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    c0 = 0; c1 = 0; lr1 = 0; prev1 = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (bus0.done && c0 == 0) c0 = cyc;
      if (bus1.done && c1 == 0) c1 = cyc;
      if (bus1.done && !prev1) lr1 = cyc;
      prev1 = bus1.done;
      start = (cyc == p1) || (cyc == p2);
    end
    start = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.d%0d.busy", tag, i), 32'(d_busy[i]), 32'd0);
      chk($sformatf("%s.d%0d.done", tag, i), 32'(d_done[i]), 32'd0);
      chk($sformatf("%s.d%0d.pass", tag, i), 32'(d_pass[i]), 32'd0);
      chk($sformatf("%s.d%0d.x", tag, i), 32'(d_x[i]), 32'd0);
      chk($sformatf("%s.d%0d.ta", tag, i), 32'(d_ta[i]), 32'd0);
      chk($sformatf("%s.d%0d.tb", tag, i), 32'(d_tb[i]), 32'd0);
      chk($sformatf("%s.d%0d.ma", tag, i), 32'(d_ma[i]), 32'd0);
      chk($sformatf("%s.d%0d.mb", tag, i), 32'(d_mb[i]), 32'd0);
    end
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #2 rst = 1'b0;

    // golden channels
    flip_a = '0; flip_b = '0;
    run_sweep(0, 0);
    chk("gold.done_cyc0", 32'(c0), 32'd48);
    chk("gold.done_cyc1", 32'(c1), 32'd32);
    chk("gold.ta", 32'(bus0.table_a), 32'h0000F272);
    chk("gold.tb", 32'(bus0.table_b), 32'h0000F266);
    chk("gold.ma", 32'(bus0.mism_a), 32'h0);
    chk("gold.mb", 32'(bus0.mism_b), 32'h0);
    chk("gold.pass", 32'(bus0.pass), 32'd1);

    // in_b stuck at 0
    flip_a = '0; flip_b = EB;
    run_sweep(0, 0);
    chk("tie_b.tb", 32'(bus0.table_b), 32'h0);
    chk("tie_b.mb", 32'(bus0.mism_b), 32'h0000F266);
    chk("tie_b.ma", 32'(bus0.mism_a), 32'h0);
    chk("tie_b.pass", 32'(bus0.pass), 32'd0);

    // single-minterm fault on channel A
    flip_a = 16'h0080; flip_b = '0;
    run_sweep(0, 0);
    chk("m7.ta", 32'(bus0.table_a), 32'h0000F2F2);
    chk("m7.ma", 32'(bus0.mism_a), 32'h00000080);
    chk("m7.pass", 32'(bus0.pass), 32'd0);

    // start while busy is ignored
    flip_a = '0; flip_b = '0;
    run_sweep(5, 20);
    chk("repulse.done_cyc0", 32'(c0), 32'd48);
    chk("repulse.ta", 32'(bus0.table_a), 32'h0000F272);
    chk("repulse.tb", 32'(bus0.table_b), 32'h0000F266);
    chk("repulse.pass", 32'(bus0.pass), 32'd1);

    // reset mid-sweep at vector 5
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    w = 0;
    while (d_x[0] != 4'd5 && w < 100) begin
      @(posedge clk); #2;
      w++;
    end
    chk("rst.reach_idx5", 32'(w < 100), 32'd1);
    rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk); #2 rst = 1'b0;
    run_sweep(0, 0);
    chk("postrst.pass0", 32'(bus0.pass), 32'd1);
    chk("postrst.pass1", 32'(bus1.pass), 32'd1);
    chk("postrst.ta", 32'(bus0.table_a), 32'h0000F272);

    // start while done restarts the SETTLE=1 sweeper only
    run_sweep(40, 0);
    chk("restart.first_done1", 32'(c1), 32'd32);
    chk("restart.second_done1", 32'(lr1), 32'd73);
    chk("restart.pass1", 32'(bus1.pass), 32'd1);

    // random fault sets and stray start pulses
    for (int r = 0; r < 20; r++) begin
      flip_a = (r % 4 == 0) ? 16'h0 : 16'($urandom);
      flip_b = (r % 3 == 0) ? 16'h0 : 16'($urandom);
      run_sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : 0,
                int'($urandom_range(1, 47)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
